// File: rtl/permuter_arb_stage_pkg.sv
// Shared definitions for the 2x2 arbitrating permuter stage: mode encodings and default widths.
package permuter_arb_stage_pkg;

    localparam logic [1:0] PERM_MODE_ARB      = 2'd0;
    localparam logic [1:0] PERM_MODE_STRAIGHT = 2'd1;
    localparam logic [1:0] PERM_MODE_SWAP     = 2'd2;
    localparam logic [1:0] PERM_MODE_RSVD     = 2'd3;

    localparam int unsigned PERM_DATA_W = 128;
    localparam int unsigned PERM_PRIO_W = 8;
    localparam int unsigned PERM_CNT_W  = 16;

endpackage

// File: rtl/permuter_arbiter.sv
// Combinational swap decision: priority arbitration with round-robin tie-break, plus
// per-input deflect flags (indexed by input, so they can travel with the flits).
module permuter_arbiter
    import permuter_arb_stage_pkg::*;
#(
    parameter int unsigned PRIO_W = PERM_PRIO_W
) (
    input  logic [1:0]        valid,
    input  logic [1:0]        dir,
    input  logic [PRIO_W-1:0] prio0,
    input  logic [PRIO_W-1:0] prio1,
    input  logic              rr,
    input  logic [1:0]        mode,
    output logic              swap,
    output logic              tie_used,
    output logic [1:0]        deflect
);

    logic tie;
    logic win1;
    logic arb_swap;

    assign tie = (valid == 2'b11) && (prio0 == prio1);

    always_comb begin
        win1 = 1'b0;
        unique case (valid)
            2'b01:   win1 = 1'b0;
            2'b10:   win1 = 1'b1;
            2'b11:   win1 = tie ? rr : (prio1 > prio0);
            default: win1 = 1'b0;
        endcase
    end

    // The winner lands on its desired port; the loser takes whatever is left.
    assign arb_swap = (valid != 2'b00) && (win1 ? ~dir[1] : dir[0]);

    always_comb begin
        swap     = arb_swap;
        tie_used = 1'b0;
        unique case (mode)
            PERM_MODE_STRAIGHT: swap = 1'b0;
            PERM_MODE_SWAP:     swap = 1'b1;
            default: begin
                swap     = arb_swap;
                tie_used = tie;
            end
        endcase
    end

    // in0 leaves on port 'swap', in1 on port '~swap'.
    assign deflect[0] = valid[0] & (swap ^ dir[0]);
    assign deflect[1] = valid[1] & ~(swap ^ dir[1]);

endmodule

// File: rtl/permuter_arb_stage.sv
// Pipelined 2x2 permuter node: arbitrated straight/swap, registered outputs, stall and a
// saturating deflection counter.
module permuter_arb_stage
    import permuter_arb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = PERM_DATA_W,
    parameter int unsigned PRIO_W = PERM_PRIO_W,
    parameter int unsigned CNT_W  = PERM_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [1:0]        mode,
    input  logic [1:0]        in_valid,
    input  logic [1:0]        in_dir,
    input  logic [PRIO_W-1:0] in_prio0,
    input  logic [PRIO_W-1:0] in_prio1,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic [1:0]        out_valid,
    output logic [PRIO_W-1:0] out_prio0,
    output logic [PRIO_W-1:0] out_prio1,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [1:0]        out_deflect,
    output logic [CNT_W-1:0]  deflect_cnt
);

    logic              rr_q;
    logic              swap;
    logic              tie_used;
    logic [1:0]        deflect_in;
    logic [1:0]        valid_d;
    logic [1:0]        deflect_d;
    logic [PRIO_W-1:0] prio0_m, prio1_m;
    logic [DATA_W-1:0] data0_m, data1_m;
    logic [1:0]        pop;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_d;

    permuter_arbiter #(
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .valid    (in_valid),
        .dir      (in_dir),
        .prio0    (in_prio0),
        .prio1    (in_prio1),
        .rr       (rr_q),
        .mode     (mode),
        .swap     (swap),
        .tie_used (tie_used),
        .deflect  (deflect_in)
    );

    // Empty slots carry zero payload and priority.
    assign prio0_m = in_valid[0] ? in_prio0 : '0;
    assign prio1_m = in_valid[1] ? in_prio1 : '0;
    assign data0_m = in_valid[0] ? in_data0 : '0;
    assign data1_m = in_valid[1] ? in_data1 : '0;

    assign valid_d   = swap ? {in_valid[0], in_valid[1]} : in_valid;
    assign deflect_d = swap ? {deflect_in[0], deflect_in[1]} : deflect_in;

    assign pop     = {1'b0, deflect_d[0]} + {1'b0, deflect_d[1]};
    assign cnt_sum = {1'b0, deflect_cnt} + {{(CNT_W-1){1'b0}}, pop};
    assign cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= '0;
            out_prio0   <= '0;
            out_prio1   <= '0;
            out_data0   <= '0;
            out_data1   <= '0;
            out_deflect <= '0;
            deflect_cnt <= '0;
            rr_q        <= 1'b0;
        end else if (!hold) begin
            out_valid   <= valid_d;
            out_prio0   <= swap ? prio1_m : prio0_m;
            out_prio1   <= swap ? prio0_m : prio1_m;
            out_data0   <= swap ? data1_m : data0_m;
            out_data1   <= swap ? data0_m : data1_m;
            out_deflect <= deflect_d;
            deflect_cnt <= cnt_d;
            if (tie_used) begin
                rr_q <= ~rr_q;
            end
        end
    end

endmodule

// File: doc/permuter_arb_stage.md
# permuter_arb_stage

Parametrised, pipelined 2x2 permuter stage for the deflection-routed permutation network. It generalises the fixed-width straight/swap element. The stage decides the swap itself by priority arbitration with a round-robin tie-break, registers its outputs, supports stall, and counts deflections. One instance forms one node of the multi-stage permutation network between router input latches and output ports.

## Interface
Parameters:
- `DATA_W`, 128: payload width per flit.
- `PRIO_W`, 8: priority/age field width; larger value means older and wins.
- `CNT_W`, 16: deflection counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `hold` in 1: stall; freezes all state.
- `mode` in 2: 0 = arbitrate, 1 = force straight, 2 = force swap, 3 = reserved (treated as arbitrate).
- `in_valid` in 2: per-input flit valid.
- `in_dir` in 2: desired output port per input (0 = out0, 1 = out1).
- `in_prio0`, `in_prio1` in PRIO_W: priorities.
- `in_data0`, `in_data1` in DATA_W: payloads.
- `out_valid` out 2: registered output valid.
- `out_prio0`, `out_prio1` out PRIO_W: registered priorities, which travel with the flits.
- `out_data0`, `out_data1` out DATA_W: registered payloads.
- `out_deflect` out 2: registered; set when the flit on that output did not get its desired port.
- `deflect_cnt` out CNT_W: saturating count of deflected flits since reset.

## Operation
- Winner selection (mode 0/3):
  - Only one input valid: that input wins.
  - Both valid and priorities differ: the higher priority wins.
  - Both valid and priorities equal: round-robin pointer `rr` picks, where 0 means in0 wins. `rr` toggles after every tie resolved in a non-held cycle.
  - Neither valid: no winner; swap = 0.
- Swap decision: the winner goes to its `in_dir` port and the other flit goes to the remaining port. swap = (winner in0 and in_dir[0]=1) or (winner in1 and in_dir[1]=0).
- Mode 1 forces swap = 0 and mode 2 forces swap = 1. In both forced modes `rr` does not change.
- Valid, priority, data and deflect travel together through the swap. Invalid slots carry data/prio = 0.
- A flit's deflect bit is 1 when it is valid and its output port differs from its `in_dir`. This applies in all modes.
- `deflect_cnt` adds popcount(next out_deflect), 0..2, each non-held cycle and saturates at all-ones.
- `hold` = 1: output registers, `rr` and `deflect_cnt` keep their values and inputs are ignored. Upstream must keep its flits until `hold` drops.

## Timing
- Latency: exactly 1 cycle from inputs to registered outputs when `hold` = 0. Throughput is 2 flits/cycle.
- Reset values: `out_valid` = 0, `out_prio*` = 0, `out_data*` = 0, `out_deflect` = 0, `deflect_cnt` = 0, `rr` = 0.
- Reset wins over `hold`. Reset mid-traffic drops in-flight flits; the cycle after reset deasserts accepts new inputs normally.
- A mode change takes effect on the same-cycle decision. There is no mode pipeline.
- Saturation: at all-ones the counter stays at all-ones and does not wrap, even when adding 2.

## Structure
- Shared package: mode encodings (`PERM_MODE_ARB`, `PERM_MODE_STRAIGHT`, `PERM_MODE_SWAP`) and default widths.
- Sub-module `permuter_arbiter`: combinational winner/swap/deflect decision from valid, dir, prio, rr and mode. It outputs `swap`, `tie_used` and `deflect[1:0]`. The top level holds the registers, the data permute muxes, `rr` and the counter.

## Test plan
- Reset: hold `reset` low for 2 cycles with valid inputs -> all outputs 0 and `deflect_cnt` = 0; first post-reset flits appear 1 cycle later.
- Priority conflict: in0 prio 5, dir 1; in1 prio 9, dir 1 -> out1 = in1 with deflect 0; out0 = in0 with deflect 1; `deflect_cnt` increments by 1.
- Tie round-robin: both prio 3, dir 0, for 3 consecutive cycles -> out0 winner is in0, then in1, then in0; `rr` toggles each cycle.
- Single flit and forced modes: only in1 valid, dir 0 -> swap, out0 = in1, `out_valid` = 2'b01. Mode 1 with in0 dir 1 -> out0 = in0, deflect 1. Mode 2 -> always crossed.
- Hold: assert `hold` for 4 cycles while inputs change -> outputs, `rr` and `deflect_cnt` unchanged; release -> next-cycle outputs reflect current inputs.
- Saturation: CNT_W = 4, drive 10 double-deflect cycles using mode 2 with matching dirs -> `deflect_cnt` reaches 15 and stays at 15.
